// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside DE: RAW stall/forward, WAW ordering,
// writeback-port collision avoidance and branch flush for variable-latency producers.
module hazard_scoreboard #(
    parameter  int NREGS  = 32,
    parameter  int LAT_W  = 3,
    parameter  int CNT_W  = 16,
    localparam int RA_W   = $clog2(NREGS),
    localparam int MAXLAT = (1 << LAT_W) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             de_valid,
    input  logic [RA_W-1:0]  de_rs1,
    input  logic [RA_W-1:0]  de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [RA_W-1:0]  de_rd,
    input  logic             de_reg_wr,
    input  logic [LAT_W-1:0] de_lat,
    input  logic             branchTaken,
    output logic             stallDE,
    output logic             issue,
    output logic             forwA,
    output logic             forwB,
    output logic             flush,
    output logic             sb_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [LAT_W-1:0]  cnt [NREGS];
    logic [MAXLAT:1]   slot;
    logic [MAXLAT:1]   slot_nxt;
    logic [MAXLAT+1:0] slot_x;
    logic [LAT_W-1:0]  lat;
    logic [LAT_W:0]    lat_p1;
    logic              raw1;
    logic              raw2;
    logic              waw;
    logic              coll;
    logic              hazard;
    logic              live;
    logic              wr_ok;

    always_comb begin
        lat    = (de_lat == '0) ? LAT_W'(1) : de_lat;
        lat_p1 = {1'b0, lat} + (LAT_W + 1)'(1);
        // Padded copy: index MAXLAT+1 reads a constant 0, so the top
        // latency never reports a collision beyond range.
        slot_x = {1'b0, slot, 1'b0};
        raw1   = de_rs1_used && (de_rs1 != '0) && (cnt[de_rs1] > LAT_W'(1));
        raw2   = de_rs2_used && (de_rs2 != '0) && (cnt[de_rs2] > LAT_W'(1));
        waw    = de_reg_wr && (de_rd != '0) && (cnt[de_rd] > lat);
        coll   = de_reg_wr && slot_x[lat_p1];
        hazard = raw1 || raw2 || waw || coll;
        live   = !reset && de_valid && !branchTaken;
        stallDE = live && hazard;
        issue   = live && !hazard;
        flush   = !reset && branchTaken;
        forwA = !reset && de_rs1_used && (de_rs1 != '0) && (cnt[de_rs1] == LAT_W'(1));
        forwB = !reset && de_rs2_used && (de_rs2 != '0) && (cnt[de_rs2] == LAT_W'(1));
        wr_ok = issue && de_reg_wr && (de_rd != '0);
    end

    always_comb begin
        slot_nxt = slot >> 1;
        if (wr_ok) slot_nxt[lat] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
            slot      <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_ok && (de_rd == RA_W'(i)))
                    cnt[i] <= lat;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - LAT_W'(1);
            end
            slot <= slot_nxt;
            if (stallDE && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign sb_busy = |slot;

endmodule
